// File: rtl/operand_fetch_stage.sv
// Operand fetch: issues register-file reads, holds operands across downstream stalls, owns the writeback port.
// Optional macro OPERAND_WB_FORWARD_EN forwards later writebacks into the pending entry.
module operand_fetch_stage #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NUM_REGS      = 32,
  parameter int unsigned REG_IDX_WIDTH = $clog2(NUM_REGS),
  parameter int unsigned TAG_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic                     i_src1_en,
  input  logic                     i_src2_en,
  input  logic [REG_IDX_WIDTH-1:0] i_src1,
  input  logic [REG_IDX_WIDTH-1:0] i_src2,
  input  logic [TAG_WIDTH-1:0]     i_tag,
  output logic                     rf_read1_en,
  output logic                     rf_read2_en,
  output logic [REG_IDX_WIDTH-1:0] rf_read1_addr,
  output logic [REG_IDX_WIDTH-1:0] rf_read2_addr,
  input  logic [DATA_WIDTH-1:0]    rf_read1_data,
  input  logic [DATA_WIDTH-1:0]    rf_read2_data,
  input  logic                     wb_en,
  input  logic [REG_IDX_WIDTH-1:0] wb_reg,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  output logic                     rf_write_en,
  output logic [REG_IDX_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0]    rf_write_data,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [DATA_WIDTH-1:0]    o_op1,
  output logic [DATA_WIDTH-1:0]    o_op2,
  output logic [TAG_WIDTH-1:0]     o_tag
);

  logic                     f_valid_q, f_valid_d;
  logic                     f_held_q, f_held_d;
  logic                     f_en1_q, f_en1_d, f_en2_q, f_en2_d;
  logic [REG_IDX_WIDTH-1:0] f_src1_q, f_src1_d, f_src2_q, f_src2_d;
  logic [TAG_WIDTH-1:0]     f_tag_q, f_tag_d;
  logic [DATA_WIDTH-1:0]    hold1_q, hold1_d, hold2_q, hold2_d;

  logic accept;
  logic fwd1, fwd2;
  logic [DATA_WIDTH-1:0] cur1, cur2;

  // Handshake, read issue and writeback passthrough
  always_comb begin
    i_ready       = !f_valid_q || o_ready;
    accept        = i_valid && i_ready;
    rf_read1_en   = accept && i_src1_en && !reset;
    rf_read2_en   = accept && i_src2_en && !reset;
    rf_read1_addr = i_src1;
    rf_read2_addr = i_src2;
    rf_write_en   = wb_en && !reset;
    rf_write_addr = wb_reg;
    rf_write_data = wb_data;
  end

  // Forward hits only apply to a live entry that actually uses the source
  always_comb begin
`ifdef OPERAND_WB_FORWARD_EN
    fwd1 = wb_en && f_valid_q && f_en1_q && (wb_reg == f_src1_q);
    fwd2 = wb_en && f_valid_q && f_en2_q && (wb_reg == f_src2_q);
`else
    fwd1 = 1'b0;
    fwd2 = 1'b0;
`endif
  end

  // Current operand value before masking unused sources
  always_comb begin
    cur1 = fwd1 ? wb_data : (f_held_q ? hold1_q : rf_read1_data);
    cur2 = fwd2 ? wb_data : (f_held_q ? hold2_q : rf_read2_data);
    o_valid = f_valid_q;
    o_op1   = f_en1_q ? cur1 : '0;
    o_op2   = f_en2_q ? cur2 : '0;
    o_tag   = f_tag_q;
  end

  // Entry state: accept wins over consume; a stall latches the live operand
  always_comb begin
    f_valid_d = f_valid_q;
    f_held_d  = f_held_q;
    f_en1_d   = f_en1_q;
    f_en2_d   = f_en2_q;
    f_src1_d  = f_src1_q;
    f_src2_d  = f_src2_q;
    f_tag_d   = f_tag_q;
    hold1_d   = hold1_q;
    hold2_d   = hold2_q;
    if (accept) begin
      f_valid_d = 1'b1;
      f_held_d  = 1'b0;
      f_en1_d   = i_src1_en;
      f_en2_d   = i_src2_en;
      f_src1_d  = i_src1;
      f_src2_d  = i_src2;
      f_tag_d   = i_tag;
    end else if (f_valid_q && o_ready) begin
      f_valid_d = 1'b0;
      f_held_d  = 1'b0;
    end else if (f_valid_q) begin
      f_held_d = 1'b1;
      hold1_d  = cur1;
      hold2_d  = cur2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_valid_q <= 1'b0;
      f_held_q  <= 1'b0;
      f_en1_q   <= 1'b0;
      f_en2_q   <= 1'b0;
      f_src1_q  <= '0;
      f_src2_q  <= '0;
      f_tag_q   <= '0;
      hold1_q   <= '0;
      hold2_q   <= '0;
    end else begin
      f_valid_q <= f_valid_d;
      f_held_q  <= f_held_d;
      f_en1_q   <= f_en1_d;
      f_en2_q   <= f_en2_d;
      f_src1_q  <= f_src1_d;
      f_src2_q  <= f_src2_d;
      f_tag_q   <= f_tag_d;
      hold1_q   <= hold1_d;
      hold2_q   <= hold2_d;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: SRAM model, scoreboard of expected operands, vector table and corner sequences.
module tb_operand_fetch_stage;

`ifdef OPERAND_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_valid = 1'b0, i_ready;
  logic        i_src1_en = 1'b0, i_src2_en = 1'b0;
  logic [4:0]  i_src1 = '0, i_src2 = '0;
  logic [7:0]  i_tag = '0;
  logic        rf_read1_en, rf_read2_en;
  logic [4:0]  rf_read1_addr, rf_read2_addr;
  logic [31:0] rf_read1_data = '0, rf_read2_data = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_data = '0;
  logic        rf_write_en;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic        o_valid, o_ready = 1'b1;
  logic [31:0] o_op1, o_op2;
  logic [7:0]  o_tag;

  operand_fetch_stage dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(i_ready),
    .i_src1_en(i_src1_en), .i_src2_en(i_src2_en), .i_src1(i_src1), .i_src2(i_src2),
    .i_tag(i_tag), .rf_read1_en(rf_read1_en), .rf_read2_en(rf_read2_en),
    .rf_read1_addr(rf_read1_addr), .rf_read2_addr(rf_read2_addr),
    .rf_read1_data(rf_read1_data), .rf_read2_data(rf_read2_data),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_op1(o_op1), .o_op2(o_op2), .o_tag(o_tag)
  );

  always #5 clk = ~clk;

  // Block-SRAM model: 1-cycle read, new data on read-during-write, garbage when not read
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (rf_write_en) mem[rf_write_addr] <= rf_write_data;
    rf_read1_data <= !rf_read1_en ? 32'hDEAD_BEEF :
                     (rf_write_en && rf_write_addr == rf_read1_addr) ? rf_write_data : mem[rf_read1_addr];
    rf_read2_data <= !rf_read2_en ? 32'hDEAD_BEEF :
                     (rf_write_en && rf_write_addr == rf_read2_addr) ? rf_write_data : mem[rf_read2_addr];
  end

  typedef struct {
    logic [31:0] x1;
    logic [31:0] x2;
    logic [7:0]  tag;
  } exp_t;

  typedef struct {
    logic [4:0]  s1;
    logic        e1;
    logic [4:0]  s2;
    logic        e2;
    logic [7:0]  tag;
    logic [31:0] x1;
    logic [31:0] x2;
  } vec_t;

  exp_t        sb[$];
  exp_t        cur;
  int          vec_cnt = 0;
  int          err_cnt = 0;
  vec_t        tbl[6];
  int          tries;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pop on consume, push on accept
  always @(negedge clk) begin
    if (!reset) begin
      if (o_valid && o_ready) begin
        if (sb.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL unexpected_output: got op1 %h with no pending entry at %0t", o_op1, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_op1", o_op1, e.x1);
          check("sb_op2", o_op2, e.x2);
          check("sb_tag", 32'(o_tag), 32'(e.tag));
        end
      end
      if (i_valid && i_ready) sb.push_back(cur);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1'b1; wb_reg = r; wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  task automatic send(input logic [4:0] s1, input logic e1, input logic [4:0] s2, input logic e2,
                      input logic [7:0] tag, input logic [31:0] x1, input logic [31:0] x2,
                      input bit rnd, output int n_wait);
    bit done = 1'b0;
    i_valid = 1'b1; i_src1 = s1; i_src1_en = e1; i_src2 = s2; i_src2_en = e2; i_tag = tag;
    cur = '{x1: x1, x2: x2, tag: tag};
    n_wait = 0;
    for (int n = 0; n < 50 && !done; n++) begin
      if (rnd) o_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (i_ready) begin
        done = 1'b1;
        check("rd1_en", 32'(rf_read1_en), 32'(e1));
        check("rd2_en", 32'(rf_read2_en), 32'(e2));
        if (e1) check("rd1_addr", 32'(rf_read1_addr), 32'(s1));
        if (e2) check("rd2_addr", 32'(rf_read2_addr), 32'(s2));
      end else n_wait++;
      step();
    end
    if (!done) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL accept_timeout: got no i_ready in 50 cycles, required accept");
    end
    i_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required end of test");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{s1: 5'd8,  e1: 1'b1, s2: 5'd9,  e2: 1'b1, tag: 8'h10, x1: 32'hA500_0008, x2: 32'hA500_0009};
    tbl[1] = '{s1: 5'd10, e1: 1'b1, s2: 5'd10, e2: 1'b1, tag: 8'h11, x1: 32'hA500_000A, x2: 32'hA500_000A};
    tbl[2] = '{s1: 5'd11, e1: 1'b0, s2: 5'd12, e2: 1'b1, tag: 8'h12, x1: 32'h0,         x2: 32'hA500_000C};
    tbl[3] = '{s1: 5'd13, e1: 1'b1, s2: 5'd14, e2: 1'b0, tag: 8'h13, x1: 32'hA500_000D, x2: 32'h0};
    tbl[4] = '{s1: 5'd0,  e1: 1'b0, s2: 5'd0,  e2: 1'b0, tag: 8'h14, x1: 32'h0,         x2: 32'h0};
    tbl[5] = '{s1: 5'd15, e1: 1'b1, s2: 5'd8,  e2: 1'b1, tag: 8'hFF, x1: 32'hA500_000F, x2: 32'hA500_0008};

    // Reset: read/write enables forced low even with requests present
    i_valid = 1'b1; i_src1_en = 1'b1; wb_en = 1'b1; wb_reg = 5'd31; wb_data = 32'hBAD0_BAD0;
    step();
    @(negedge clk);
    check("rst_rd1_en", 32'(rf_read1_en), 32'd0);
    check("rst_wr_en", 32'(rf_write_en), 32'd0);
    step();
    reset = 1'b0; i_valid = 1'b0; i_src1_en = 1'b0; wb_en = 1'b0;
    @(negedge clk);
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_i_ready", 32'(i_ready), 32'd1);
    check("rst_o_op1", o_op1, 32'd0);
    check("rst_o_op2", o_op2, 32'd0);
    check("rst_o_tag", 32'(o_tag), 32'd0);
    step();

    wr(5'd3, 32'h1234); wr(5'd1, 32'hA); wr(5'd2, 32'hB); wr(5'd5, 32'h55);
    wr(5'd7, 32'h70); wr(5'd4, 32'h40);
    for (int i = 8; i < 16; i++) wr(5'(i), 32'hA500_0000 | 32'(i));

    // Single read, src2 unused
    send(5'd3, 1'b1, 5'd0, 1'b0, 8'h01, 32'h1234, 32'h0, 1'b0, tries);
    @(negedge clk);
    check("t1_o_valid", 32'(o_valid), 32'd1);
    check("t1_op1", o_op1, 32'h1234);
    check("t1_op2", o_op2, 32'h0);
    check("t1_i_ready", 32'(i_ready), 32'd1);
    step();

    // Back-to-back, no bubble
    send(5'd1, 1'b1, 5'd0, 1'b0, 8'h02, 32'hA, 32'h0, 1'b0, tries);
    send(5'd2, 1'b1, 5'd0, 1'b0, 8'h03, 32'hB, 32'h0, 1'b0, tries);
    check("t2_no_bubble", 32'(tries), 32'd0);
    @(negedge clk);
    check("t2_op1_second", o_op1, 32'hB);
    step();

    // Stall for 3 cycles with a held-off request
    send(5'd5, 1'b1, 5'd0, 1'b0, 8'h05, 32'h55, 32'h0, 1'b0, tries);
    o_ready = 1'b0;
    i_valid = 1'b1; i_src1 = 5'd3; i_src1_en = 1'b1; i_src2_en = 1'b0; i_tag = 8'h06;
    cur = '{x1: 32'h1234, x2: 32'h0, tag: 8'h06};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_o_valid", 32'(o_valid), 32'd1);
      check("t3_op1_held", o_op1, 32'h55);
      check("t3_i_ready", 32'(i_ready), 32'd0);
      check("t3_no_read", 32'(rf_read1_en), 32'd0);
      step();
    end
    o_ready = 1'b1;
    @(negedge clk);
    check("t3_release_i_ready", 32'(i_ready), 32'd1);
    step();
    i_valid = 1'b0;
    step();

    // Same-cycle write and read of r7
    wb_en = 1'b1; wb_reg = 5'd7; wb_data = 32'h77;
    send(5'd7, 1'b1, 5'd0, 1'b0, 8'h07, 32'h77, 32'h0, 1'b0, tries);
    wb_en = 1'b0;
    step();

    // Writeback to a stalled entry's source
    send(5'd4, 1'b1, 5'd4, 1'b1, 8'h08, FWD ? 32'h44 : 32'h40, FWD ? 32'h44 : 32'h40, 1'b0, tries);
    o_ready = 1'b0;
    @(negedge clk);
    check("t5_first_stall", o_op1, 32'h40);
    step();
    wb_en = 1'b1; wb_reg = 5'd4; wb_data = 32'h44;
    @(negedge clk);
    check("t5_wr_en", 32'(rf_write_en), 32'd1);
    check("t5_wr_addr", 32'(rf_write_addr), 32'd4);
    check("t5_wr_data", rf_write_data, 32'h44);
    check("t5_wb_cycle", o_op1, FWD ? 32'h44 : 32'h40);
    step();
    wb_en = 1'b0;
    @(negedge clk);
    check("t5_after_wb", o_op1, FWD ? 32'h44 : 32'h40);
    check("t5_after_wb_op2", o_op2, FWD ? 32'h44 : 32'h40);
    step();
    o_ready = 1'b1;
    step();

    // Vector table, full throughput then random backpressure
    for (int i = 0; i < 6; i++)
      send(tbl[i].s1, tbl[i].e1, tbl[i].s2, tbl[i].e2, tbl[i].tag, tbl[i].x1, tbl[i].x2, 1'b0, tries);
    for (int i = 0; i < 6; i++)
      send(tbl[i].s1, tbl[i].e1, tbl[i].s2, tbl[i].e2, tbl[i].tag, tbl[i].x1, tbl[i].x2, 1'b1, tries);
    o_ready = 1'b1;
    repeat (3) step();
    check("drain_empty", 32'(sb.size()), 32'd0);

    // Reset while stalled drops the entry
    send(5'd5, 1'b1, 5'd0, 1'b0, 8'h09, 32'h55, 32'h0, 1'b0, tries);
    o_ready = 1'b0;
    @(negedge clk);
    check("t6_stalled_valid", 32'(o_valid), 32'd1);
    step();
    reset = 1'b1; sb.delete();
    o_ready = 1'b1; i_valid = 1'b1; i_src1 = 5'd3; i_src1_en = 1'b1; wb_en = 1'b1;
    @(negedge clk);
    check("t6_rst_rd1_en", 32'(rf_read1_en), 32'd0);
    check("t6_rst_wr_en", 32'(rf_write_en), 32'd0);
    step();
    reset = 1'b0; i_valid = 1'b0; i_src1_en = 1'b0; wb_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_o_valid", 32'(o_valid), 32'd0);
      check("t6_i_ready", 32'(i_ready), 32'd1);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
